// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave port between NUM_MASTERS requesters.
// A grant covers a whole transaction; reads that never return are ended by a timeout with SLVERROR.
module avalon_mm_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*32-1:0]         m_writedata,
    input  logic [NUM_MASTERS*4-1:0]          m_byteenable,
    output logic [NUM_MASTERS-1:0]            m_waitrequest,
    output logic [31:0]                       m_readdata,
    output logic [NUM_MASTERS-1:0]            m_readdatavalid,
    output logic [1:0]                        m_response,
    output logic [ADDR_WIDTH-1:0]             avl_mm_addr,
    output logic                              avl_mm_read,
    output logic                              avl_mm_write,
    output logic [31:0]                       avl_mm_writedata,
    output logic [3:0]                        avl_mm_byteenable,
    input  logic                              avl_mm_waitrequest,
    input  logic                              avl_mm_readdatavalid,
    input  logic [31:0]                       avl_mm_readdata,
    input  logic [1:0]                        avl_mm_response,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              timeout_pulse
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CMD, RDWAIT, TMO} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       cand;
    logic                   pick_valid;
    logic [CNT_W-1:0]       tmo_cnt;
    logic                   late_pending;
    logic [NUM_MASTERS-1:0] eligible;
    logic                   g_read;
    logic                   g_write;

    // A read cannot be started while the slave still owes data for a timed-out read.
    assign eligible = (m_read | m_write) & ~({NUM_MASTERS{late_pending}} & m_read);

    // last_grant doubles as the index of the current owner once a grant is issued.
    assign g_read  = m_read[last_grant];
    assign g_write = m_write[last_grant];

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_MASTERS);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next        = state;
        m_waitrequest     = '1;
        m_readdatavalid   = '0;
        m_readdata        = '0;
        m_response        = '0;
        timeout_pulse     = 1'b0;
        avl_mm_addr       = '0;
        avl_mm_read       = 1'b0;
        avl_mm_write      = 1'b0;
        avl_mm_writedata  = '0;
        avl_mm_byteenable = '0;
        case (state)
            IDLE: begin
                if (pick_valid) state_next = CMD;
            end
            CMD: begin
                avl_mm_addr       = m_addr[last_grant*ADDR_WIDTH +: ADDR_WIDTH];
                avl_mm_writedata  = m_writedata[last_grant*32 +: 32];
                avl_mm_byteenable = m_byteenable[last_grant*4 +: 4];
                // Read and write together is a protocol error; the read wins.
                avl_mm_read       = g_read;
                avl_mm_write      = g_write & ~g_read;
                m_waitrequest[last_grant] = avl_mm_waitrequest;
                if (!(g_read || g_write)) begin
                    state_next = IDLE;
                end else if (!avl_mm_waitrequest) begin
                    state_next = g_read ? RDWAIT : IDLE;
                end
            end
            RDWAIT: begin
                if (avl_mm_readdatavalid) begin
                    m_readdatavalid[last_grant] = 1'b1;
                    m_readdata                  = avl_mm_readdata;
                    m_response                  = avl_mm_response;
                    state_next                  = IDLE;
                end else if (tmo_cnt == CNT_MAX) begin
                    state_next = TMO;
                end
            end
            TMO: begin
                m_readdatavalid[last_grant] = 1'b1;
                m_response                  = 2'b10;
                timeout_pulse               = 1'b1;
                state_next                  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= LAST_IDX;
            tmo_cnt      <= '0;
            late_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && pick_valid) begin
                grant      <= NUM_MASTERS'(1) << pick_idx;
                last_grant <= pick_idx;
            end else if (state_next == IDLE) begin
                grant <= '0;
            end
            if (state == CMD && state_next == RDWAIT) begin
                tmo_cnt <= '0;
            end else if (state == RDWAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // The abandoned read's data, whenever it shows up, is swallowed here.
            if (state == TMO) begin
                late_pending <= 1'b1;
            end else if (avl_mm_readdatavalid) begin
                late_pending <= 1'b0;
            end
        end
    end

endmodule
